// File: rtl/ifft_frame_ctrl.sv
// IFFT wrapper around a forward FFT core: conj in, conj out, >>> OUT_SHIFT scaling; 1-cycle load latency, output valid 1 cycle after fft_done.
// Input stalls (s_ready=0) from the last bin until the drain completes; the output register holds while m_valid & !m_ready. Optional cyclic prefix: IFFT_CP_INSERT_EN.
module ifft_frame_ctrl #(
    parameter int N_PTS        = 64,
    parameter int LOG2N        = 6,
    parameter int DW           = 16,
    parameter int OUT_SHIFT    = 6,
    parameter int DONE_TIMEOUT = 1024,
    parameter int CP_LEN       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_re,
    input  logic [DW-1:0]    s_im,
    output logic             fft_load_valid,
    output logic [DW-1:0]    fft_load_re,
    output logic [DW-1:0]    fft_load_im,
    input  logic             fft_done,
    output logic [LOG2N-1:0] fft_read_addr,
    input  logic [DW-1:0]    fft_read_re,
    input  logic [DW-1:0]    fft_read_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_re,
    output logic [DW-1:0]    m_im,
    output logic             m_last,
    output logic             o_busy,
    output logic             o_timeout_err
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

`ifdef IFFT_CP_INSERT_EN
    localparam int CP_EN = 1;
`else
    localparam int CP_EN = 0;
`endif
    localparam int CP_OFF = (CP_EN != 0) ? CP_LEN : 0;
    localparam int RD_W   = LOG2N + CP_EN;
    localparam int N_OUT  = N_PTS + CP_OFF;
    localparam int TO_W   = $clog2(DONE_TIMEOUT);

    localparam logic [LOG2N-1:0] BIN_LAST = LOG2N'(N_PTS - 1);
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(N_OUT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DONE_TIMEOUT - 1);

    function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] r;
        if (v == {1'b1, {(DW-1){1'b0}}})
            r = {1'b0, {(DW-1){1'b1}}};
        else
            r = -v;
        return r;
    endfunction

    logic [1:0]       state;
    logic [LOG2N-1:0] bin_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [RD_W-1:0]  rd_cnt;

    logic                 s_fire;
    logic                 issue;
    logic signed [DW-1:0] rd_re_s;
    logic signed [DW-1:0] rd_im_neg;

    assign s_fire    = s_valid && s_ready;
    assign rd_re_s   = $signed(fft_read_re);
    assign rd_im_neg = neg_sat(fft_read_im);
    assign o_busy    = (state != ST_LOAD);

    // With N_PTS a power of two, (rd_cnt - CP_OFF) mod N_PTS walks the prefix
    // tail first and then the whole frame; without the prefix it is just rd_cnt.
    assign fft_read_addr = LOG2N'(rd_cnt - RD_W'(CP_OFF));

    // The first sample is captured on the done edge itself so m_valid follows
    // fft_done by one cycle; afterwards refill whenever the register drains.
    assign issue = ((state == ST_WAIT) && fft_done) ||
                   ((state == ST_DRAIN) && (!m_valid || (m_ready && !m_last)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_LOAD;
            bin_cnt        <= '0;
            to_cnt         <= '0;
            rd_cnt         <= '0;
            s_ready        <= 1'b0;
            fft_load_valid <= 1'b0;
            fft_load_re    <= '0;
            fft_load_im    <= '0;
            m_valid        <= 1'b0;
            m_re           <= '0;
            m_im           <= '0;
            m_last         <= 1'b0;
            o_timeout_err  <= 1'b0;
        end else begin
            fft_load_valid <= 1'b0;
            case (state)
                ST_LOAD: begin
                    s_ready <= 1'b1;
                    if (s_fire) begin
                        fft_load_valid <= 1'b1;
                        fft_load_re    <= s_re;
                        fft_load_im    <= neg_sat(s_im);
                        if (bin_cnt == BIN_LAST) begin
                            state   <= ST_WAIT;
                            s_ready <= 1'b0;
                            bin_cnt <= '0;
                            to_cnt  <= '0;
                        end else begin
                            bin_cnt <= bin_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (fft_done) begin
                        state <= ST_DRAIN;
                    end else if (to_cnt == TO_LAST) begin
                        state         <= ST_LOAD;
                        s_ready       <= 1'b1;
                        o_timeout_err <= 1'b1;
                        to_cnt        <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        state   <= ST_LOAD;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        rd_cnt  <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase

            if (issue) begin
                m_valid <= 1'b1;
                m_re    <= rd_re_s >>> OUT_SHIFT;
                m_im    <= rd_im_neg >>> OUT_SHIFT;
                m_last  <= (rd_cnt == RD_LAST);
                rd_cnt  <= rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Directed bench for ifft_frame_ctrl with a behavioural DFT core model behind the load/read ports.
module tb_ifft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_re, s_im;
    logic        fft_load_valid;
    logic [15:0] fft_load_re, fft_load_im;
    logic        fft_done;
    logic [5:0]  fft_read_addr;
    logic [15:0] fft_read_re, fft_read_im;
    logic        m_valid, m_ready;
    logic [15:0] m_re, m_im;
    logic        m_last;
    logic        o_busy, o_timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifft_frame_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .fft_load_valid(fft_load_valid), .fft_load_re(fft_load_re), .fft_load_im(fft_load_im),
        .fft_done(fft_done), .fft_read_addr(fft_read_addr),
        .fft_read_re(fft_read_re), .fft_read_im(fft_read_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_last(m_last),
        .o_busy(o_busy), .o_timeout_err(o_timeout_err)
    );

    // core model: capture loaded bins, forward DFT on request, combinational read
    logic signed [15:0] ld_re [64];
    logic signed [15:0] ld_im [64];
    logic [15:0] core_re [64];
    logic [15:0] core_im [64];
    int ld_n;

    always @(posedge clk) begin
        if (rst) ld_n <= 0;
        else if (fft_load_valid) begin
            ld_re[ld_n] <= fft_load_re;
            ld_im[ld_n] <= fft_load_im;
            ld_n <= (ld_n + 1) % 64;
        end
    end

    assign fft_read_re = core_re[fft_read_addr];
    assign fft_read_im = core_im[fft_read_addr];

    function automatic int rnd_sat(input real v);
        int r;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic core_compute();
        real sr, si, ang, a, b;
        for (int k = 0; k < 64; k++) begin
            sr = 0.0; si = 0.0;
            for (int n = 0; n < 64; n++) begin
                a = real'(ld_re[n]); b = real'(ld_im[n]);
                ang = 6.283185307179586 * real'(k * n) / 64.0;
                sr = sr + a * $cos(ang) + b * $sin(ang);
                si = si + b * $cos(ang) - a * $sin(ang);
            end
            core_re[k] = 16'(rnd_sat(sr));
            core_im[k] = 16'(rnd_sat(si));
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp);
        n_assert++;
        assert ((obs - exp) >= -1 && (obs - exp) <= 1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
        end
    endtask

    int fr_re [64];
    int fr_im [64];
    int out_re [200];
    int out_im [200];
    int ld0_re, ld0_im, ld0_vld;

    task automatic set_frame(input int re0, input int im0, input int idx);
        for (int i = 0; i < 64; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[idx] = re0; fr_im[idx] = im0;
    endtask

    task automatic load_frame();
        int i, cyc;
        logic acc;
        i = 0; cyc = 0;
        while (i < 64 && cyc < 1000) begin
            s_valid = 1'b1;
            s_re = 16'(fr_re[i]);
            s_im = 16'(fr_im[i]);
            acc = s_ready;
            @(posedge clk); #1; cyc++;
            if (acc) begin
                if (i == 0) begin
                    ld0_vld = int'(fft_load_valid);
                    ld0_re = int'($signed(fft_load_re));
                    ld0_im = int'($signed(fft_load_im));
                end
                i++;
            end
        end
        s_valid = 1'b0;
        chk("load_count", i, 64);
    endtask

    task automatic pulse_done();
        core_compute();
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
        chk("first_valid_after_done", int'(m_valid), 1);
    endtask

    task automatic drain(input logic use_bp, output int n_hs, output int last_idx, output int n_last);
        logic [3:0]  bp_pat;
        logic        prev_stall, fin;
        logic [15:0] hold_re, hold_im;
        int cyc, hold_bad, sready_bad;
        bp_pat = 4'b1001;
        n_hs = 0; n_last = 0; last_idx = -1; cyc = 0;
        hold_bad = 0; sready_bad = 0; prev_stall = 1'b0;
        hold_re = '0; hold_im = '0; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            m_ready = use_bp ? bp_pat[cyc % 4] : 1'b1;
            if (prev_stall && (m_re !== hold_re || m_im !== hold_im || !m_valid)) hold_bad++;
            if (s_ready) sready_bad++;
            if (m_valid && m_ready) begin
                out_re[n_hs] = int'($signed(m_re));
                out_im[n_hs] = int'($signed(m_im));
                if (m_last) begin n_last++; last_idx = n_hs; end
                n_hs++;
            end
            prev_stall = m_valid && !m_ready;
            hold_re = m_re; hold_im = m_im;
            fin = m_valid && m_ready && m_last;
            @(posedge clk); #1; cyc++;
        end
        m_ready = 1'b1;
        chk("drain_finished_in_budget", int'(fin), 1);
        chk("data_held_during_stall", hold_bad, 0);
        chk("s_ready_low_while_draining", sready_bad, 0);
        chk("after_drain_m_valid", int'(m_valid), 0);
        chk("after_drain_s_ready", int'(s_ready), 1);
        chk("after_drain_busy", int'(o_busy), 0);
    endtask

    int nh, li, nl;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; fft_done = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_load_valid", int'(fft_load_valid), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_re", int'(m_re), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_read_addr", int'(fft_read_addr), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_timeout_err", int'(o_timeout_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("s_ready_after_rst", int'(s_ready), 1);

        // fft_done outside WAIT has no effect
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
        @(posedge clk); #1;
        chk("done_in_load_busy", int'(o_busy), 0);
        chk("done_in_load_m_valid", int'(m_valid), 0);

        // impulse: every output (16,0)
        set_frame(1024, 0, 0);
        load_frame();
        chk("imp_load_valid", ld0_vld, 1);
        chk("imp_load_re", ld0_re, 1024);
        chk("imp_busy_in_wait", int'(o_busy), 1);
        @(posedge clk); #1;
        chk("idle_load_valid_low", int'(fft_load_valid), 0);
        pulse_done();
        drain(1'b0, nh, li, nl);
        chk("imp_count", nh, 64);
        chk("imp_last_idx", li, 63);
        chk("imp_last_count", nl, 1);
        for (int i = 0; i < 64; i++) begin
            chk_near("imp_re", out_re[i], 16);
            chk_near("imp_im", out_im[i], 0);
        end

        // tone on bin 1
        set_frame(2048, 0, 1);
        load_frame();
        pulse_done();
        drain(1'b0, nh, li, nl);
        chk("tone_count", nh, 64);
        chk_near("tone_x0_re", out_re[0], 32);
        chk_near("tone_x0_im", out_im[0], 0);
        chk_near("tone_x16_re", out_re[16], 0);
        chk_near("tone_x16_im", out_im[16], 32);
        chk_near("tone_x32_re", out_re[32], -32);
        chk_near("tone_x32_im", out_im[32], 0);
        chk_near("tone_x48_re", out_re[48], 0);
        chk_near("tone_x48_im", out_im[48], -32);

        // imaginary impulse under 1,0,0,1 backpressure: every output (0,16)
        set_frame(0, 1024, 0);
        load_frame();
        chk("imag_load_im", ld0_im, -1024);
        pulse_done();
        drain(1'b1, nh, li, nl);
        chk("bp_count", nh, 64);
        chk("bp_last_idx", li, 63);
        chk("bp_last_count", nl, 1);
        for (int i = 0; i < 64; i += 9) begin
            chk("bp_re", out_re[i], 0);
            chk("bp_im", out_im[i], 16);
        end

        // conjugate saturation: -32768 loads as 32767, output im = -32767 >>> 6 = -512
        set_frame(0, -32768, 0);
        load_frame();
        chk("sat_load_im", ld0_im, 32767);
        pulse_done();
        drain(1'b0, nh, li, nl);
        chk("sat_count", nh, 64);
        chk("sat_x0_re", out_re[0], 0);
        chk("sat_x0_im", out_im[0], -512);
        chk("sat_x63_im", out_im[63], -512);

        // timeout: 1024 cycles in WAIT without done
        set_frame(1024, 0, 0);
        load_frame();
        repeat (1023) @(posedge clk);
        #1;
        chk("to_err_before", int'(o_timeout_err), 0);
        chk("to_busy_before", int'(o_busy), 1);
        @(posedge clk); #1;
        chk("to_err_set", int'(o_timeout_err), 1);
        chk("to_s_ready", int'(s_ready), 1);
        chk("to_busy_after", int'(o_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("to_err_sticky", int'(o_timeout_err), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("to_err_cleared", int'(o_timeout_err), 0);
        @(posedge clk); #1;

        // reset in the middle of a stalled drain
        set_frame(1024, 0, 0);
        load_frame();
        pulse_done();
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_drain_holding", int'(m_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_s_ready", int'(s_ready), 1);

        // clean frame after the aborted one
        set_frame(1024, 0, 0);
        load_frame();
        pulse_done();
        drain(1'b0, nh, li, nl);
        chk("recover_count", nh, 64);
        chk_near("recover_x5_re", out_re[5], 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
